acc_rd_seq: RTL
===============

# acc_rd_seq

Parametrised accumulator read sequencer for the systolic TPU datapath. It generates per-column read enables and addresses for the accumulator banks in either NORMAL mode (all columns read the same row in lockstep) or DIAG mode (column c lags column 0 by c cycles, de-skewing systolic output). It generalises the fixed 32-column, 7-bit diagonal address set in `tpu_package` to any column count and address width, and adds a programmable base, row count, stall and completion handshake. It sits between the instruction decoder and the accumulator banks.

## Interface
Parameters:
- MUL_SIZE, 32, number of accumulator columns.
- ACC_ADDR_W, 7, accumulator row-address width.
- LEN_W, 8, width of the row-count field.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  request a read burst; sampled only in IDLE.
- mode_i  in  1  `acc_rd_mode` from `tpu_package`: 0 = NORMAL, 1 = DIAG; latched on start.
- base_addr_i  in  ACC_ADDR_W  first row address; latched on start.
- num_rows_i  in  LEN_W  rows per column; latched on start.
- stall_i  in  1  downstream back-pressure; freezes the sequence.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle completion pulse.
- rd_en_o  out  MUL_SIZE  per-column read enable.
- rd_addr_o  out  MUL_SIZE*ACC_ADDR_W  per-column address; column c at bits [c*ACC_ADDR_W +: ACC_ADDR_W].

## Operation
- States: IDLE, RUN.
- IDLE, start_i=1, num_rows_i!=0: latch mode, base, rows; clear step counter t; next state RUN.
- IDLE, start_i=1, num_rows_i=0: no RUN; done_o pulses next cycle, no rd_en.
- start_i while in RUN is ignored (not queued).
- Total steps T = rows in NORMAL, rows + MUL_SIZE - 1 in DIAG. t width is LEN_W+$clog2(MUL_SIZE)+1; no overflow.
- Column c active at step t when t >= lag_c and t - lag_c < rows, with lag_c = 0 (NORMAL) or c (DIAG).
- rd_en_o[c] = RUN & ~stall_i & active_c (combinational from registered state).
- rd_addr_o[c] = base + (t - lag_c), truncated mod 2^ACC_ADDR_W (wrap-around is legal and silent). Inactive columns drive 0.
- t increments on every RUN cycle with stall_i=0. The non-stalled step t=T-1 moves to IDLE and sets done_o for the following cycle.
- Stall on the final step delays done_o accordingly.

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, rd_en_o 0, rd_addr_o 0, all latches 0.
- Latency: start accepted in cycle N; first rd_en_o in cycle N+1 (if no stall).
- Unstalled burst occupies T consecutive RUN cycles. done_o is high in cycle N+1+T, with busy_o already 0.
- A new start_i in the done_o cycle is accepted (state is IDLE), giving back-to-back bursts with one idle cycle.
- Each stall cycle adds exactly one cycle; addresses hold their values across it.
- rst_n low mid-burst: immediate return to reset values. No done_o is issued for the aborted burst.

## Configuration
- ACC_RD_DIAG_EN defined: NORMAL and DIAG modes as above.
- Not defined: mode_i is ignored and treated as NORMAL, lag_c is always 0, and T = rows. DIAG lag logic and the wider counter are not synthesised (t is LEN_W bits).

## Test plan
Bench overrides MUL_SIZE=4, ACC_ADDR_W=7, LEN_W=8.
- NORMAL, base=10, rows=3: cycles N+1..N+3 show rd_en_o=4'b1111 with all addresses 10, 11, 12. done_o at N+4.
- DIAG, base=10, rows=3: T=6. Column 0 reads 10, 11, 12 at steps 0–2; column 3 reads 10, 11, 12 at steps 3–5. At step 2, rd_en_o=4'b0111 and addresses are {—, 10, 11, 12} for columns 3..0. done_o at N+7.
- Wrap: NORMAL, base=126, rows=4 gives addresses 126, 127, 0, 1.
- Stall: NORMAL, rows=3, stall_i high at step 1 for 2 cycles. rd_en_o is 0 for those cycles, address 11 is held, and done_o is delayed by 2 to N+6.
- rows=0: start gives done_o at N+1, rd_en_o never asserted. rst_n pulled low at step 2 of a DIAG burst clears all outputs immediately, and no done_o follows.
- Build without ACC_RD_DIAG_EN: mode_i=1, rows=3 behaves identically to the NORMAL vector above.

Source files
------------

// File: rtl/acc_rd_seq.sv
//----------------------------------------------------------------------------
// Module      : acc_rd_seq
// Description : Accumulator read sequencer. Issues per-column read enables
//               and row addresses for the accumulator banks, either with all
//               columns in lockstep (NORMAL) or with column c lagging column
//               0 by c cycles (DIAG) to de-skew systolic output.
//               Optional feature macro: ACC_RD_DIAG_EN (enables DIAG mode and
//               the wider step counter; without it mode_i is ignored).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module acc_rd_seq #(
  parameter int MUL_SIZE   = 32,
  parameter int ACC_ADDR_W = 7,
  parameter int LEN_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           mode_i,
  input  logic [ACC_ADDR_W-1:0]          base_addr_i,
  input  logic [LEN_W-1:0]               num_rows_i,
  input  logic                           stall_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [MUL_SIZE-1:0]            rd_en_o,
  output logic [MUL_SIZE*ACC_ADDR_W-1:0] rd_addr_o
);

`ifdef ACC_RD_DIAG_EN
  // Step counter must reach rows + MUL_SIZE - 1 without overflow.
  localparam int TW = LEN_W + $clog2(MUL_SIZE) + 1;
`else
  localparam int TW = LEN_W;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    done_q;
  logic [ACC_ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]        rows_q;
  logic [TW-1:0]           t_q;
  logic [TW-1:0]           t_d;
  logic [TW-1:0]           w_total;
  logic                    w_last;
  logic                    w_busy;

`ifdef ACC_RD_DIAG_EN
  logic                    mode_q;
  // DIAG bursts run MUL_SIZE-1 extra steps so the last column can drain.
  assign w_total = TW'(rows_q) + (mode_q ? TW'(MUL_SIZE - 1) : '0);
`else
  // Mode input has no effect in this build.
  logic                    w_unused_mode;
  assign w_unused_mode = mode_i;
  assign w_total       = TW'(rows_q);
`endif

  assign t_d    = t_q + TW'(1);
  assign w_last = (t_q == (w_total - TW'(1)));
  assign w_busy = (state_q == ST_RUN);
  assign busy_o = w_busy;
  assign done_o = done_q;

  // Control FSM: latch the burst on start, step t on every non-stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      base_q  <= '0;
      rows_q  <= '0;
      t_q     <= '0;
`ifdef ACC_RD_DIAG_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (num_rows_i != '0) begin
              state_q <= ST_RUN;
              base_q  <= base_addr_i;
              rows_q  <= num_rows_i;
              t_q     <= '0;
`ifdef ACC_RD_DIAG_EN
              mode_q  <= mode_i;
`endif
            end else begin
              // Empty burst completes immediately without reading.
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!stall_i) begin
            t_q <= t_d;
            if (w_last) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Per-column activity window and address, derived from the shared step t.
  for (genvar c = 0; c < MUL_SIZE; c++) begin : g_col
    logic [TW-1:0] w_rel;
    logic          w_act;
`ifdef ACC_RD_DIAG_EN
    logic [TW-1:0] w_lag;
    assign w_lag = mode_q ? TW'(c) : '0;
    assign w_rel = t_q - w_lag;
    assign w_act = w_busy && (t_q >= w_lag) && (w_rel < TW'(rows_q));
`else
    assign w_rel = t_q;
    assign w_act = w_busy && (t_q < TW'(rows_q));
`endif
    assign rd_en_o[c] = w_act & ~stall_i;
    // Address stays visible during a stall; rows wrap silently.
    assign rd_addr_o[c*ACC_ADDR_W +: ACC_ADDR_W] =
      w_act ? (base_q + ACC_ADDR_W'(w_rel)) : '0;
  end

endmodule

`default_nettype wire
